// File: rtl/sf_camera_clk_pkg.sv
// Shared definitions for the camera clock divider: channel states, divisor floor
// and the high-phase length helper.
package sf_camera_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } ch_state_e;

  localparam int unsigned MIN_DIV = 32'd2;

  // High phase is the ceiling half so odd divisors spend the extra cycle high.
  function automatic int unsigned hi_count(input int unsigned d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/sf_camera_clk_div_ch.sv
// One divider channel: IDLE/RUN/STOP sequencing, phase counter, pending divisor
// and lock tracking, with every output taken straight from a flop.
module sf_camera_clk_div_ch
  import sf_camera_clk_pkg::*;
#(
  parameter int unsigned DIV_WIDTH    = 8,
  parameter int unsigned DEFAULT_DIV  = 5,
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic                 i_update,
  output logic                 o_clk,
  output logic                 o_rise,
  output logic                 o_locked,
  output logic                 o_busy
);

  localparam logic [7:0]           LOCK_N   = 8'(LOCK_PERIODS);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(32'd1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);

  ch_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [7:0]           per_q, per_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 locked_q, locked_d;
  logic                 busy_q, busy_d;

  logic [DIV_WIDTH-1:0] div_in_s;
  logic [DIV_WIDTH-1:0] hi_s;
  logic                 wrap_s;
  logic                 apply_s;

  // Next-state logic: divisor changes only land on a wrap so no runt phase appears.
  always_comb begin
    div_in_s   = (i_divisor < DIV_MIN) ? DIV_MIN : i_divisor;
    wrap_s     = (cnt_q == (div_q - DIV_ONE));
    apply_s    = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    per_d      = per_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        per_d      = '0;
        pend_vld_d = 1'b0;
        if (i_update) begin
          div_d = div_in_s;
        end else if (pend_vld_q) begin
          div_d = pend_q;
        end else begin
          div_d = div_q;
        end
        if (i_enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_STOP: begin
        if (wrap_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
        apply_s = wrap_s && pend_vld_q;
        if (apply_s) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
        end else begin
          div_d      = div_q;
        end
        // An update landing on the same edge as a wrap waits for the following wrap.
        if (i_update) begin
          pend_d     = div_in_s;
          pend_vld_d = 1'b1;
        end else begin
          pend_d     = pend_q;
        end
        if (i_enable) begin
          state_d = ST_RUN;
        end else if (wrap_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
        if ((state_d != ST_RUN) || apply_s) begin
          per_d = '0;
        end else if (wrap_s && (state_q == ST_RUN) && (per_q < LOCK_N)) begin
          per_d = per_q + 8'd1;
        end else begin
          per_d = per_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        per_d      = '0;
        pend_vld_d = 1'b0;
      end
    endcase
    hi_s     = DIV_WIDTH'(hi_count(32'(div_d)));
    busy_d   = (state_d != ST_IDLE);
    clk_d    = busy_d && (cnt_d < hi_s);
    rise_d   = clk_d && !clk_q;
    locked_d = (per_d == LOCK_N);
  end

  // Channel state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_RST;
      pend_q     <= DIV_RST;
      pend_vld_q <= 1'b0;
      per_q      <= '0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      per_q      <= per_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
    end
  end

  assign o_clk    = clk_q;
  assign o_rise   = rise_q;
  assign o_locked = locked_q;
  assign o_busy   = busy_q;

endmodule

// File: rtl/sf_camera_clk_div.sv
// Multi-channel fabric clock divider for camera pad clocks; each channel is an
// independent sf_camera_clk_div_ch with its own divisor slice.
module sf_camera_clk_div #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DIV_WIDTH    = 8,
  parameter int unsigned DEFAULT_DIV  = 5,
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           i_enable,
  input  logic [NUM_CH*DIV_WIDTH-1:0] i_divisor,
  input  logic [NUM_CH-1:0]           i_update,
  output logic [NUM_CH-1:0]           o_clk,
  output logic [NUM_CH-1:0]           o_rise,
  output logic [NUM_CH-1:0]           o_locked,
  output logic [NUM_CH-1:0]           o_busy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sf_camera_clk_div_ch #(
      .DIV_WIDTH    (DIV_WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .LOCK_PERIODS (LOCK_PERIODS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_enable  (i_enable[g]),
      .i_divisor (i_divisor[g*DIV_WIDTH +: DIV_WIDTH]),
      .i_update  (i_update[g]),
      .o_clk     (o_clk[g]),
      .o_rise    (o_rise[g]),
      .o_locked  (o_locked[g]),
      .o_busy    (o_busy[g])
    );
  end

endmodule

// File: tb/tb_sf_camera_clk_div.sv
// Directed bench for sf_camera_clk_div: a period-arithmetic reference model checked
// every cycle, plus hand-computed waveform points for each scenario.
module tb_sf_camera_clk_div;

  localparam int NCH  = 2;
  localparam int DW   = 8;
  localparam int DEF  = 5;
  localparam int LOCK = 4;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    upd;
  logic [DW-1:0]     dv [NCH];
  logic [NCH*DW-1:0] divisor;
  logic [NCH-1:0]    o_clk, o_rise, o_locked, o_busy;

  assign divisor = {dv[1], dv[0]};

  sf_camera_clk_div #(
    .NUM_CH       (NCH),
    .DIV_WIDTH    (DW),
    .DEFAULT_DIV  (DEF),
    .LOCK_PERIODS (LOCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (en),
    .i_divisor (divisor),
    .i_update  (upd),
    .o_clk     (o_clk),
    .o_rise    (o_rise),
    .o_locked  (o_locked),
    .o_busy    (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: state is 0 idle, 1 run, 2 stop; the phase is derived from the
  // edge number relative to the epoch where the current divisor started at phase 0.
  int m_st    [NCH];
  int m_d     [NCH];
  int m_pend  [NCH];
  int m_epoch [NCH];
  int m_lockf [NCH];
  bit e_clk   [NCH];
  bit e_rise  [NCH];
  bit e_lock  [NCH];
  bit e_busy  [NCH];
  int edge_n = 0;

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_st[ch] = 0; m_d[ch] = DEF; m_pend[ch] = 0; m_epoch[ch] = 0; m_lockf[ch] = 0;
      e_clk[ch] = 0; e_rise[ch] = 0; e_lock[ch] = 0; e_busy[ch] = 0;
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int ch = 0; ch < NCH; ch++) begin
      int  cl;
      bit  wrap;
      bit  prev;
      cl = (int'(dv[ch]) < 2) ? 2 : int'(dv[ch]);
      if (m_st[ch] == 0) begin
        if (m_pend[ch] != 0) begin m_d[ch] = m_pend[ch]; m_pend[ch] = 0; end
        if (upd[ch]) m_d[ch] = cl;
        if (en[ch]) begin m_st[ch] = 1; m_epoch[ch] = edge_n; m_lockf[ch] = edge_n; end
      end else begin
        wrap = ((edge_n - m_epoch[ch]) % m_d[ch]) == 0;
        if (wrap && m_pend[ch] != 0) begin
          m_d[ch] = m_pend[ch]; m_pend[ch] = 0; m_epoch[ch] = edge_n; m_lockf[ch] = edge_n;
        end
        if (upd[ch]) m_pend[ch] = cl;
        if (en[ch]) begin
          if (m_st[ch] == 2) m_lockf[ch] = edge_n;
          m_st[ch] = 1;
        end else if (wrap) m_st[ch] = 0;
        else m_st[ch] = 2;
      end
      prev        = e_clk[ch];
      e_busy[ch]  = (m_st[ch] != 0);
      e_clk[ch]   = e_busy[ch] &&
                    (((edge_n - m_epoch[ch]) % m_d[ch]) < (m_d[ch] - m_d[ch] / 2));
      e_rise[ch]  = e_clk[ch] && !prev;
      e_lock[ch]  = (m_st[ch] == 1) &&
                    (((edge_n - m_epoch[ch]) / m_d[ch]) - ((m_lockf[ch] - m_epoch[ch]) / m_d[ch]) >= LOCK);
    end
  endtask

  // Every falling edge: compare against the model, then advance it with the inputs
  // that the next rising edge will sample.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
        chk($sformatf("mdl_clk ch%0d", ch),    o_clk[ch],    e_clk[ch]);
        chk($sformatf("mdl_rise ch%0d", ch),   o_rise[ch],   e_rise[ch]);
        chk($sformatf("mdl_locked ch%0d", ch), o_locked[ch], e_lock[ch]);
        chk($sformatf("mdl_busy ch%0d", ch),   o_busy[ch],   e_busy[ch]);
      end
      if (rst) model_edge();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [4:0] pat;

  initial begin
    pat = 5'b00111;
    rst = 1'b1; en = '0; upd = '0; dv[0] = 8'd5; dv[1] = 8'd5;
    #2 rst = 1'b0;
    tick(2);
    chk("rst_clk", o_clk, 32'd0);
    chk("rst_rise", o_rise, 32'd0);
    chk("rst_locked", o_locked, 32'd0);
    chk("rst_busy", o_busy, 32'd0);
    rst = 1'b1;
    tick(1);

    // D=5 from enable: 1,1,1,0,0 with lock after the fourth wrap.
    dv[0] = 8'd5; en[0] = 1'b1;
    tick(1);
    for (int i = 0; i <= 20; i++) begin
      chk("d5_clk", o_clk[0], pat[i % 5]);
      chk("d5_rise", o_rise[0], (i % 5) == 0);
      chk("d5_locked", o_locked[0], i >= 20);
      if (i < 20) tick(1);
    end

    // Update to 8 while at phase 1 of a D=5 period.
    tick(1);
    dv[0] = 8'd8; upd[0] = 1'b1;
    tick(1);
    upd[0] = 1'b0;
    for (int j = 0; j <= 35; j++) begin
      case (j)
        0:  begin chk("upd8_clk0", o_clk[0], 1); chk("upd8_lock0", o_locked[0], 1); end
        1:  chk("upd8_clk1", o_clk[0], 0);
        2:  chk("upd8_lock2", o_locked[0], 1);
        3:  begin
              chk("upd8_clk3", o_clk[0], 1); chk("upd8_rise3", o_rise[0], 1);
              chk("upd8_lock3", o_locked[0], 0);
            end
        6:  chk("upd8_clk6", o_clk[0], 1);
        7:  chk("upd8_clk7", o_clk[0], 0);
        10: chk("upd8_clk10", o_clk[0], 0);
        11: begin chk("upd8_clk11", o_clk[0], 1); chk("upd8_rise11", o_rise[0], 1); end
        34: chk("upd8_lock34", o_locked[0], 0);
        35: chk("upd8_lock35", o_locked[0], 1);
        default: ;
      endcase
      if (j < 35) tick(1);
    end

    // Divisors 0 and 1 clamp to 2; 3 gives 2 high / 1 low.
    en[0] = 1'b0;
    dv[1] = 8'd0; upd[1] = 1'b1;
    tick(1);
    upd[1] = 1'b0; en[1] = 1'b1;
    tick(1);
    for (int j = 0; j <= 5; j++) begin
      chk("d0_clk", o_clk[1], (j % 2) == 0);
      chk("d0_rise", o_rise[1], (j % 2) == 0);
      if (j < 5) tick(1);
    end
    en[1] = 1'b0;
    tick(2);
    chk("d0_idle_busy", o_busy[1], 0);
    dv[1] = 8'd1; upd[1] = 1'b1;
    tick(1);
    upd[1] = 1'b0; en[1] = 1'b1;
    tick(1);
    for (int j = 0; j <= 3; j++) begin
      chk("d1_clk", o_clk[1], (j % 2) == 0);
      if (j < 3) tick(1);
    end
    en[1] = 1'b0;
    tick(3);
    dv[1] = 8'd3; upd[1] = 1'b1;
    tick(1);
    upd[1] = 1'b0; en[1] = 1'b1;
    tick(1);
    for (int j = 0; j <= 5; j++) begin
      chk("d3_clk", o_clk[1], (j % 3) != 2);
      chk("d3_rise", o_rise[1], (j % 3) == 0);
      if (j < 5) tick(1);
    end
    en[1] = 1'b0;
    tick(3);

    // D=6 stop: disable at phase 1, period completes then idles.
    chk("stop_pre_busy", o_busy[0], 0);
    dv[0] = 8'd6; upd[0] = 1'b1;
    tick(1);
    upd[0] = 1'b0; en[0] = 1'b1;
    tick(2);
    en[0] = 1'b0;
    tick(1);
    chk("stop_clk_hi", o_clk[0], 1); chk("stop_busy_hi", o_busy[0], 1);
    tick(3);
    chk("stop_clk_lo", o_clk[0], 0); chk("stop_busy_lo", o_busy[0], 1);
    tick(1);
    chk("stop_clk_end", o_clk[0], 0); chk("stop_busy_end", o_busy[0], 0);
    chk("stop_rise_end", o_rise[0], 0);
    tick(2);
    chk("stop_clk_hold", o_clk[0], 0);

    // Same, but enable returns at phase 4: no gap, next period starts on time.
    en[0] = 1'b1;
    tick(2);
    en[0] = 1'b0;
    tick(3);
    en[0] = 1'b1;
    tick(1);
    chk("resume_busy5", o_busy[0], 1); chk("resume_clk5", o_clk[0], 0);
    tick(1);
    chk("resume_clk6", o_clk[0], 1); chk("resume_rise6", o_rise[0], 1);
    chk("resume_busy6", o_busy[0], 1);

    // Two updates (7 then 9) inside one D=6 period: only 9 takes effect.
    tick(1);
    dv[0] = 8'd7; upd[0] = 1'b1;
    tick(1);
    dv[0] = 8'd9;
    tick(1);
    upd[0] = 1'b0;
    for (int j = 0; j <= 12; j++) begin
      case (j)
        1:  chk("lw_clk1", o_clk[0], 0);
        2:  chk("lw_clk2", o_clk[0], 0);
        3:  begin chk("lw_clk3", o_clk[0], 1); chk("lw_rise3", o_rise[0], 1); end
        7:  chk("lw_clk7", o_clk[0], 1);
        8:  chk("lw_clk8", o_clk[0], 0);
        11: chk("lw_clk11", o_clk[0], 0);
        12: begin chk("lw_clk12", o_clk[0], 1); chk("lw_rise12", o_rise[0], 1); end
        default: ;
      endcase
      if (j < 12) tick(1);
    end

    // Reset mid-period with D=4 and D=7, enables held high across it.
    en = '0;
    tick(10);
    dv[0] = 8'd4; dv[1] = 8'd7; upd = 2'b11;
    tick(1);
    upd = '0; en = 2'b11;
    tick(3);
    chk("pre_rst_clk", o_clk, 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_clk", o_clk, 32'd0);
    chk("mid_rst_rise", o_rise, 32'd0);
    chk("mid_rst_locked", o_locked, 32'd0);
    chk("mid_rst_busy", o_busy, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("restart_clk", o_clk, 32'd3); chk("restart_rise", o_rise, 32'd3);
    tick(3);
    chk("restart_clk3", o_clk, 32'd0); chk("restart_busy3", o_busy, 32'd3);
    tick(2);
    chk("restart_clk5", o_clk, 32'd3); chk("restart_rise5", o_rise, 32'd3);

    // Retune channel 1 only; channel 0 keeps its D=5 cadence.
    dv[1] = 8'd3; upd[1] = 1'b1;
    tick(1);
    upd[1] = 1'b0;
    tick(22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
